// File: rtl/status_commit.sv
// Architectural status register (compressed), DF, SAHF/POPF/CLC/STC/CMC/CLD/STD commit path.
// Optional DF storage enabled by defining STATUS_DF_EN.
module status_commit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [7:0]  data_in,
  input  logic        stall,
  output logic [6:0]  status_out,
  output logic        df_out,
  output logic [7:0]  ah_image,
  output logic [15:0] flags_image,
  output logic        busy,
  output logic        err
);

  localparam logic [5:0] CMD_CLC  = 6'h01;
  localparam logic [5:0] CMD_STC  = 6'h02;
  localparam logic [5:0] CMD_CMC  = 6'h03;
  localparam logic [5:0] CMD_CLD  = 6'h04;
  localparam logic [5:0] CMD_STD  = 6'h05;
  localparam logic [5:0] CMD_SAHF = 6'h06;
  localparam logic [5:0] CMD_POPF = 6'h07;

  localparam int unsigned OF = 6, SF = 5, CF = 4, ZF = 3, AF = 2, PF = 1, IFL = 0;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, POPF_HI} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  // Shadow keeps only the low-beat bits that reach the status register: {SF,ZF,AF,PF,CF}.
  logic [4:0]  shadow_q, shadow_d;
  logic [6:0]  status_q, status_d;
  logic        err_q, err_d;
  logic        accept;
  logic        exec;
  logic        df_cur;
`ifdef STATUS_DF_EN
  logic        df_q, df_d;
`endif

  assign cmd_ready = !rst && !stall;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
`ifdef STATUS_DF_EN
      df_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      status_q <= status_d;
      err_q    <= err_d;
`ifdef STATUS_DF_EN
      df_q     <= df_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    status_d = status_q;
    err_d    = 1'b0;
    exec     = 1'b0;
`ifdef STATUS_DF_EN
    df_d     = df_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_op == CMD_POPF) begin
            shadow_d = {data_in[7], data_in[6], data_in[4], data_in[2], data_in[0]};
            cnt_d    = '0;
            state_d  = POPF_HI;
          end else begin
            exec = 1'b1;
          end
        end
      end
      POPF_HI: begin
        if (accept) begin
          state_d  = IDLE;
          shadow_d = '0;
          if (cmd_op == CMD_POPF) begin
            status_d = {data_in[3], shadow_q[4], shadow_q[0], shadow_q[3],
                        shadow_q[2], shadow_q[1], data_in[1]};
`ifdef STATUS_DF_EN
            df_d     = data_in[2];
`endif
          end else begin
            err_d = 1'b1;
            exec  = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          shadow_d = '0;
          state_d  = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Single-beat opcodes share one path so an aborting command behaves exactly as in IDLE.
    if (exec) begin
      unique case (cmd_op)
        CMD_CLC:  status_d[CF] = 1'b0;
        CMD_STC:  status_d[CF] = 1'b1;
        CMD_CMC:  status_d[CF] = ~status_q[CF];
`ifdef STATUS_DF_EN
        CMD_CLD:  df_d = 1'b0;
        CMD_STD:  df_d = 1'b1;
`endif
        CMD_SAHF: begin
          status_d[SF] = data_in[7];
          status_d[ZF] = data_in[6];
          status_d[AF] = data_in[4];
          status_d[PF] = data_in[2];
          status_d[CF] = data_in[0];
        end
        default: ;
      endcase
    end
  end

`ifdef STATUS_DF_EN
  assign df_cur = df_q;
`else
  assign df_cur = 1'b0;
`endif

  always_comb begin
    busy        = (state_q == POPF_HI);
    err         = err_q;
    status_out  = status_q;
    df_out      = df_cur;
    ah_image    = {status_q[SF], status_q[ZF], 1'b0, status_q[AF], 1'b0,
                   status_q[PF], 1'b1, status_q[CF]};
    flags_image = {4'b0000, status_q[OF], df_cur, status_q[IFL], 1'b0,
                   status_q[SF], status_q[ZF], 1'b0, status_q[AF], 1'b0,
                   status_q[PF], 1'b1, status_q[CF]};
  end

endmodule
